// File: rtl/adder_chunk.sv
// Combinational CHUNK-wide adder slice: one instance per pipeline stage.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_carry,
    output logic [CHUNK-1:0] o_sum_c,
    output logic             o_carry_c
);
    localparam int unsigned SUM_W = CHUNK + 1;

    assign {o_carry_c, o_sum_c} = SUM_W'(i_a) + SUM_W'(i_b) + SUM_W'(i_carry);

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES chunk-wide pipeline stages with a
// valid/ready stream handshake; every stage advances together on a global enable.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);
    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 1 and divisible by STAGES >= 1");
    end

    localparam int unsigned CHUNK = WIDTH / STAGES;

    logic w_adv;

    // The whole pipe moves when the output slot is empty or being drained.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned SUM_W = (k + 1) * CHUNK;
        localparam int unsigned REM_W = WIDTH - SUM_W;

        logic             w_valid;
        logic [CHUNK-1:0] w_a;
        logic [CHUNK-1:0] w_b;
        logic             w_cin;
        logic             w_sa;
        logic             w_sb;
        logic [CHUNK-1:0] w_sum;
        logic             w_cout;
        logic [SUM_W-1:0] w_sum_all;

        logic             r_valid;
        logic [SUM_W-1:0] r_sum;
        logic             r_carry;

        if (k == 0) begin : g_src_in
            assign w_valid   = in_valid;
            assign w_a       = in_a[CHUNK-1:0];
            assign w_b       = in_b[CHUNK-1:0];
            assign w_cin     = in_carry;
            assign w_sa      = in_a[WIDTH-1];
            assign w_sb      = in_b[WIDTH-1];
            assign w_sum_all = w_sum;
        end else begin : g_src_prev
            assign w_valid   = g_stage[k-1].r_valid;
            assign w_a       = g_stage[k-1].g_ops.r_a[CHUNK-1:0];
            assign w_b       = g_stage[k-1].g_ops.r_b[CHUNK-1:0];
            assign w_cin     = g_stage[k-1].r_carry;
            assign w_sa      = g_stage[k-1].g_ops.r_sa;
            assign w_sb      = g_stage[k-1].g_ops.r_sb;
            assign w_sum_all = {w_sum, g_stage[k-1].r_sum};
        end

        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .i_a      (w_a),
            .i_b      (w_b),
            .i_carry  (w_cin),
            .o_sum_c  (w_sum),
            .o_carry_c(w_cout)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
                r_carry <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_valid;
                r_sum   <= w_sum_all;
                r_carry <= w_cout;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            // Upper chunks not yet added, plus operand signs for the final stage.
            logic [REM_W-1:0] w_rem_a;
            logic [REM_W-1:0] w_rem_b;
            logic [REM_W-1:0] r_a;
            logic [REM_W-1:0] r_b;
            logic             r_sa;
            logic             r_sb;

            if (k == 0) begin : g_rem_in
                assign w_rem_a = in_a[WIDTH-1:CHUNK];
                assign w_rem_b = in_b[WIDTH-1:CHUNK];
            end else begin : g_rem_prev
                assign w_rem_a = g_stage[k-1].g_ops.r_a[REM_W+CHUNK-1:CHUNK];
                assign w_rem_b = g_stage[k-1].g_ops.r_b[REM_W+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_sa <= 1'b0;
                    r_sb <= 1'b0;
                end else if (w_adv) begin
                    r_a  <= w_rem_a;
                    r_b  <= w_rem_b;
                    r_sa <= w_sa;
                    r_sb <= w_sb;
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Signed overflow: equal operand signs but the result sign differs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= (w_sa == w_sb) && (w_sum[CHUNK-1] != w_sa);
                end
            end
        end
    end

    assign out_valid    = g_stage[STAGES-1].r_valid;
    assign out_sum      = g_stage[STAGES-1].r_sum;
    assign out_carry    = g_stage[STAGES-1].r_carry;
    assign out_overflow = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three configurations (8/2, 1/1, 16/4)
// checked against an arithmetic reference model on every emitted result.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        d8_in_valid, d8_in_ready, d8_in_carry;
    logic        d8_out_valid, d8_out_ready, d8_out_carry, d8_out_overflow;
    logic [7:0]  d8_in_a, d8_in_b, d8_out_sum;

    logic        d1_in_valid, d1_in_ready, d1_in_carry;
    logic        d1_out_valid, d1_out_ready, d1_out_carry, d1_out_overflow;
    logic [0:0]  d1_in_a, d1_in_b, d1_out_sum;

    logic        d16_in_valid, d16_in_ready, d16_in_carry;
    logic        d16_out_valid, d16_out_ready, d16_out_carry, d16_out_overflow;
    logic [15:0] d16_in_a, d16_in_b, d16_out_sum;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] q8[$];
    logic [33:0] q1[$];
    logic [33:0] q16[$];
    bit          stim_done = 1'b0;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .in_a(d8_in_a), .in_b(d8_in_b), .in_carry(d8_in_carry),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .out_sum(d8_out_sum), .out_carry(d8_out_carry), .out_overflow(d8_out_overflow)
    );

    pipelined_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_a(d1_in_a), .in_b(d1_in_b), .in_carry(d1_in_carry),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_sum(d1_out_sum), .out_carry(d1_out_carry), .out_overflow(d1_out_overflow)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .in_a(d16_in_a), .in_b(d16_in_b), .in_carry(d16_in_carry),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready),
        .out_sum(d16_out_sum), .out_carry(d16_out_carry), .out_overflow(d16_out_overflow)
    );

    // Reference: plain integer arithmetic; overflow means the signed result
    // falls outside the representable two's-complement range.
    function automatic logic [33:0] ref_add(input int w, input longint a, input longint b,
                                            input longint c);
        longint modv  = longint'(1) << w;
        longint half  = modv / 2;
        longint total = a + b + c;
        longint sa    = (a >= half) ? a - modv : a;
        longint sb    = (b >= half) ? b - modv : b;
        longint ss    = sa + sb + c;
        logic   ovf   = (ss >= half) || (ss < -half);
        logic   cout  = (total >= modv);
        return {ovf, cout, 32'(total % modv)};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop on emit, push model result on accept.
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
        end else begin
            if (d8_out_valid && d8_out_ready) begin
                if (q8.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL d8_spurious: got output 0x%0h, expected no output", d8_out_sum);
                end else begin
                    check("d8_result", {d8_out_overflow, d8_out_carry, 32'(d8_out_sum)}, q8.pop_front());
                end
            end
            if (d8_in_valid && d8_in_ready)
                q8.push_back(ref_add(8, d8_in_a, d8_in_b, d8_in_carry));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
        end else begin
            if (d1_out_valid && d1_out_ready) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL d1_spurious: got output 0x%0h, expected no output", d1_out_sum);
                end else begin
                    check("d1_result", {d1_out_overflow, d1_out_carry, 32'(d1_out_sum)}, q1.pop_front());
                end
            end
            if (d1_in_valid && d1_in_ready)
                q1.push_back(ref_add(1, d1_in_a, d1_in_b, d1_in_carry));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
        end else begin
            if (d16_out_valid && d16_out_ready) begin
                if (q16.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL d16_spurious: got output 0x%0h, expected no output", d16_out_sum);
                end else begin
                    check("d16_result", {d16_out_overflow, d16_out_carry, 32'(d16_out_sum)}, q16.pop_front());
                end
            end
            if (d16_in_valid && d16_in_ready)
                q16.push_back(ref_add(16, d16_in_a, d16_in_b, d16_in_carry));
        end
    end

    function automatic int qsize(input int which);
        case (which)
            8:       return q8.size();
            1:       return q1.size();
            default: return q16.size();
        endcase
    endfunction

    // Called at posedge+#1 with in_valid raised; returns at posedge+#1 after the accept edge.
    task automatic wait_accept(input int which);
        int n  = 0;
        bit ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            case (which)
                8:       ok = d8_in_ready;
                1:       ok = d1_in_ready;
                default: ok = d16_in_ready;
            endcase
            if (!ok) begin
                n++;
                if (n > 1000) begin
                    n_checks++; n_fail++;
                    $display("FAIL accept_timeout_%0d: in_ready stayed 0, expected 1 within 1000 cycles", which);
                    ok = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        d8_in_a = a; d8_in_b = b; d8_in_carry = c; d8_in_valid = 1'b1;
        wait_accept(8);
        d8_in_valid = 1'b0;
    endtask

    task automatic send1(input logic a, input logic b, input logic c);
        d1_in_a = a; d1_in_b = b; d1_in_carry = c; d1_in_valid = 1'b1;
        wait_accept(1);
        d1_in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
        d16_in_a = a; d16_in_b = b; d16_in_carry = c; d16_in_valid = 1'b1;
        wait_accept(16);
        d16_in_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (qsize(which) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("drain_%0d", which), qsize(which), 0);
    endtask

    // Single beat into an empty 8-bit pipe: exact latency plus constant expectations.
    task automatic directed8(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic [7:0] es, input logic ec, input logic eo);
        d8_out_ready = 1'b1;
        send8(a, b, c);
        check({name, "_early_valid"}, d8_out_valid, 0);
        @(posedge clk); #1;
        check({name, "_valid"}, d8_out_valid, 1);
        check({name, "_sum"}, d8_out_sum, es);
        check({name, "_carry"}, d8_out_carry, ec);
        check({name, "_ovf"}, d8_out_overflow, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bp_a [4];
        logic [7:0] bp_b [4];

        rst = 1'b1;
        d8_in_valid = 1'b0;  d8_in_a = '0;  d8_in_b = '0;  d8_in_carry = 1'b0;  d8_out_ready = 1'b1;
        d1_in_valid = 1'b0;  d1_in_a = '0;  d1_in_b = '0;  d1_in_carry = 1'b0;  d1_out_ready = 1'b1;
        d16_in_valid = 1'b0; d16_in_a = '0; d16_in_b = '0; d16_in_carry = 1'b0; d16_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", d8_out_valid, 0);
        check("rst_out_sum", d8_out_sum, 0);
        check("rst_out_carry", d8_out_carry, 0);
        check("rst_out_ovf", d8_out_overflow, 0);
        check("rst_in_ready", d8_in_ready, 1);
        check("rst16_out_valid", d16_out_valid, 0);
        check("rst16_in_ready", d16_in_ready, 1);

        directed8("chunk_carry", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        directed8("carry_out", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        directed8("overflow", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        directed8("neg_ovf", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Backpressure: 4 back-to-back beats, 3-cycle stall once the first result shows.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 8'(8'h11 * (i + 1));
            bp_b[i] = 8'(i + 3);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) send8(bp_a[i], bp_b[i], 1'b0);
            end
            begin
                int n = 0;
                while (!d8_out_valid && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("bp_first_valid", d8_out_valid, 1);
                d8_out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", d8_in_ready, 0);
                    check("bp_sum_held", d8_out_sum, 8'h14);
                    check("bp_valid_held", d8_out_valid, 1);
                    @(posedge clk); #1;
                end
                d8_out_ready = 1'b1;
            end
        join
        drain(8);

        // Reset with two beats in flight and the output stalled.
        d8_out_ready = 1'b0;
        send8(8'h21, 8'h05, 1'b0);
        send8(8'h33, 8'h44, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        d8_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_no_valid", d8_out_valid, 0);
            @(posedge clk); #1;
        end
        directed8("after_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        // WIDTH=1, STAGES=1: every input combination.
        d1_out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            send1(vv[2], vv[1], vv[0]);
        end
        drain(1);

        // WIDTH=16, STAGES=4: corners, then random beats under random backpressure.
        d16_out_ready = 1'b1;
        send16(16'hFFFF, 16'h0000, 1'b1);
        send16(16'h7FFF, 16'h0001, 1'b0);
        send16(16'h8000, 16'h8000, 1'b0);
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk); #1;
                    end
                    send16(16'($urandom), 16'($urandom), 1'($urandom));
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    d16_out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                d16_out_ready = 1'b1;
            end
        join
        drain(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
